// File: rtl/spectro_pkg.sv
// Shared definitions for the spectral record path: packer FSM states,
// the header sync pattern and record-length helper.
package spectro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MIN,
        ST_SEC,
        ST_BAND,
        ST_CHK
    } pack_state_e;

    localparam logic [1:0] HDR_SYNC = 2'b10;

    // Two header bytes plus one checksum byte around the band magnitudes.
    function automatic int record_len(input int n_bands);
        return n_bands + 3;
    endfunction

endpackage

// File: rtl/timestamp_packer.sv
// Latches the current time and a frame of band magnitudes, then streams
// them out as one byte-serial record with an XOR checksum.
module timestamp_packer
    import spectro_pkg::*;
#(
    parameter int N_BANDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           sec,
    input  logic [5:0]           min,
    input  logic                 ovf,
    input  logic                 frame_valid,
    input  logic [8*N_BANDS-1:0] frame_data,
    output logic                 frame_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 rst_ovf
);

    localparam int IDX_W   = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int REC_LEN = record_len(N_BANDS);
    // Index of the last band: record length minus headers, checksum and one.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 4);

    pack_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [5:0]       min_q, sec_q;
    logic             ovf_q;
    logic             rst_ovf_q;
    logic [7:0]       band_q [N_BANDS];
    logic [7:0]       frame_bands [N_BANDS];
    logic             capture;

    generate
        for (genvar gi = 0; gi < N_BANDS; gi++) begin : g_band_split
            assign frame_bands[gi] = frame_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            chk_q     <= 8'h00;
            rst_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            rst_ovf_q <= capture & ovf;
        end
    end

    // Capture registers carry data only; control state gates their use.
    always_ff @(posedge clk) begin
        if (capture) begin
            min_q  <= min;
            sec_q  <= sec;
            ovf_q  <= ovf;
            band_q <= frame_bands;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        frame_ready = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    chk_d   = 8'h00;
                    state_d = ST_MIN;
                end
            end
            ST_MIN: begin
                out_valid = 1'b1;
                out_data  = {HDR_SYNC, min_q};
                if (out_ready) state_d = ST_SEC;
            end
            ST_SEC: begin
                out_valid = 1'b1;
                out_data  = {ovf_q, 1'b0, sec_q};
                if (out_ready) state_d = ST_BAND;
            end
            ST_BAND: begin
                out_valid = 1'b1;
                out_data  = band_q[idx_q];
                if (out_ready) begin
                    if (idx_q == LAST_IDX) state_d = ST_CHK;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_CHK: begin
                out_valid = 1'b1;
                out_data  = chk_q;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (out_valid && out_ready) chk_d = chk_q ^ out_data;
    end

    assign rst_ovf = rst_ovf_q;

endmodule

// File: tb/tb_timestamp_packer.sv
// Directed checks of the timestamp packer: record contents, overflow clear,
// backpressure in both directions, mid-record reset and back-to-back rate.
module tb_timestamp_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  sec, min;
    logic        ovf;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        frame_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        rst_ovf;

    logic [5:0]  sec1, min1;
    logic        ovf1;
    logic        frame_valid1;
    logic [7:0]  frame_data1;
    logic        frame_ready1;
    logic [7:0]  out_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic        rst_ovf1;

    int total = 0;
    int bad   = 0;
    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    timestamp_packer #(.N_BANDS(4)) u_dut (
        .clk(clk), .reset(reset), .sec(sec), .min(min), .ovf(ovf),
        .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_ready(frame_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .rst_ovf(rst_ovf)
    );

    timestamp_packer #(.N_BANDS(1)) u_dut1 (
        .clk(clk), .reset(reset), .sec(sec1), .min(min1), .ovf(ovf1),
        .frame_valid(frame_valid1), .frame_data(frame_data1),
        .frame_ready(frame_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .rst_ovf(rst_ovf1)
    );

    typedef struct {
        logic [5:0]  mn;
        logic [5:0]  sc;
        logic        ov;
        logic [31:0] bands;
        logic [55:0] exp_bytes;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one frame for a single cycle, then scrambles the time inputs so
    // the record must come from the latched copy.
    task automatic start_frame(input logic [5:0] mn, input logic [5:0] sc,
                               input logic ov, input logic [31:0] bands);
        min = mn; sec = sc; ovf = ov; frame_data = bands;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        min = 6'd7; sec = 6'd13; ovf = 1'b0; frame_data = 32'hDEADBEEF;
    endtask

    // Collects accepted bytes starting at cycle T+1; out_ready is dropped for
    // stall_len cycles from cycle stall_at. Returns the cycle of the last byte.
    task automatic drain(input int stall_at, input int stall_len, input int n_bytes,
                         output int done_cyc, output int rst_first, output int rst_cnt,
                         output int ready_cnt);
        logic       prev_stalled;
        logic [7:0] prev_data;
        prev_stalled = 1'b0;
        prev_data    = 8'h00;
        done_cyc  = -1;
        rst_first = 0;
        rst_cnt   = 0;
        ready_cnt = 0;
        rx_q.delete();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == 1) rst_first = int'(rst_ovf);
            if (rst_ovf) rst_cnt++;
            if (frame_ready) ready_cnt++;
            if (prev_stalled) begin
                check($sformatf("hold_data_c%0d", cyc), int'(out_data), int'(prev_data));
                check($sformatf("hold_valid_c%0d", cyc), int'(out_valid), 1);
            end
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                if (rx_q.size() == n_bytes) done_cyc = cyc;
            end
            prev_stalled = out_valid && !out_ready;
            prev_data    = out_data;
            tick();
            if (done_cyc >= 0) break;
        end
        out_ready = 1'b1;
        check("idle_frame_ready", int'(frame_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
    endtask

    task automatic check_bytes(input string name, input logic [55:0] exp);
        check({name, "_len"}, rx_q.size(), 7);
        if (rx_q.size() == 7) begin
            for (int i = 0; i < 7; i++)
                check($sformatf("%s_b%0d", name, i), int'(rx_q[i]), int'(exp[55-8*i -: 8]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [4];
        int done, rf, rc, rdy;
        int cap_cycles [$];
        logic [7:0] q1 [$];

        vecs[0] = '{6'd5,  6'd42, 1'b0, 32'h44332211, 56'h85_2A_11_22_33_44_EB};
        vecs[1] = '{6'd0,  6'd0,  1'b1, 32'h00000000, 56'h80_80_00_00_00_00_00};
        vecs[2] = '{6'd59, 6'd59, 1'b0, 32'h01FF5AA5, 56'hBB_3B_A5_5A_FF_01_81};
        vecs[3] = '{6'd63, 6'd63, 1'b1, 32'h08040201, 56'hBF_BF_01_02_04_08_0F};

        reset = 1'b1; sec = 0; min = 0; ovf = 0; frame_valid = 0;
        frame_data = 0; out_ready = 1'b1;
        sec1 = 0; min1 = 0; ovf1 = 0; frame_valid1 = 0; frame_data1 = 0;
        out_ready1 = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_frame_ready", int'(frame_ready), 1);
        check("rst_rst_ovf", int'(rst_ovf), 0);
        reset = 1'b0;
        tick();

        // Table-driven records with out_ready held high.
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].mn, vecs[v].sc, vecs[v].ov, vecs[v].bands);
            drain(100, 0, 7, done, rf, rc, rdy);
            check_bytes($sformatf("vec%0d", v), vecs[v].exp_bytes);
            check($sformatf("vec%0d_chk_cycle", v), done, 7);
            check($sformatf("vec%0d_rst_ovf_t1", v), rf, int'(vecs[v].ov));
            check($sformatf("vec%0d_rst_ovf_cnt", v), rc, int'(vecs[v].ov));
            check($sformatf("vec%0d_busy_ready", v), rdy, 0);
        end

        // Downstream stall on the SEC byte for three cycles.
        start_frame(6'd5, 6'd42, 1'b0, 32'h44332211);
        drain(2, 3, 7, done, rf, rc, rdy);
        check_bytes("bp", 56'h85_2A_11_22_33_44_EB);
        check("bp_chk_cycle", done, 10);

        // Second frame offered mid-record and held until accepted.
        start_frame(6'd5, 6'd42, 1'b0, 32'h44332211);
        min = 6'd10; sec = 6'd20; frame_data = 32'h04030201; frame_valid = 1'b1;
        drain(100, 0, 7, done, rf, rc, rdy);
        check_bytes("stallA", 56'h85_2A_11_22_33_44_EB);
        check("stallA_busy_ready", rdy, 0);
        tick();
        frame_valid = 1'b0; min = 6'd7; sec = 6'd13; frame_data = 32'hDEADBEEF;
        drain(100, 0, 7, done, rf, rc, rdy);
        // 8A ^ 14 = 9E; ^01=9F; ^02=9D; ^04=99; ^03... bands 01,02,03,04
        check_bytes("stallB", 56'h8A_14_01_02_03_04_9A);
        repeat (3) tick();
        check("stallB_no_dup", int'(out_valid), 0);

        // Reset while band 2 is on the bus.
        start_frame(6'd5, 6'd42, 1'b1, 32'h44332211);
        repeat (4) tick();
        check("mid_band2", int'(out_data), 8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_ready", int'(frame_ready), 1);
        tick();
        check("mid_rst_ovf", int'(rst_ovf), 0);
        start_frame(6'd59, 6'd59, 1'b0, 32'h01FF5AA5);
        drain(100, 0, 7, done, rf, rc, rdy);
        check_bytes("after_rst", 56'hBB_3B_A5_5A_FF_01_81);

        // Reset coincident with an offered frame: nothing captured.
        min = 6'd1; sec = 6'd1; ovf = 1'b1; frame_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; frame_valid = 1'b0; ovf = 1'b0;
        check("rst_win_valid", int'(out_valid), 0);
        tick();
        check("rst_win_valid2", int'(out_valid), 0);
        check("rst_win_rst_ovf", int'(rst_ovf), 0);

        // N_BANDS=1 with frame_valid held: one capture every 5 cycles.
        min1 = 6'd1; sec1 = 6'd2; frame_data1 = 8'h7E; frame_valid1 = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (frame_ready1) cap_cycles.push_back(cyc);
            if (out_valid1 && out_ready1) q1.push_back(out_data1);
            tick();
        end
        frame_valid1 = 1'b0;
        check("b2b_captures", cap_cycles.size(), 4);
        if (cap_cycles.size() >= 3) begin
            check("b2b_period0", cap_cycles[1] - cap_cycles[0], 5);
            check("b2b_period1", cap_cycles[2] - cap_cycles[1], 5);
        end
        check("b2b_len", int'(q1.size() >= 4), 1);
        if (q1.size() >= 4) begin
            check("b2b_min", int'(q1[0]), 8'h81);
            check("b2b_sec", int'(q1[1]), 8'h02);
            check("b2b_band", int'(q1[2]), 8'h7E);
            check("b2b_chk", int'(q1[3]), 8'hFD);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timestamp_packer.md
# timestamp_packer

Downstream consumer of the time counter's `sec`, `min` and `ovf` outputs. When the spectral stage offers a completed frame of band magnitudes, it latches the current time and the frame. It then emits one byte-serial record over a valid/ready stream:
- header carrying the minute count
- header carrying the second count and the overflow flag
- N_BANDS magnitude bytes
- XOR checksum byte

It also issues the overflow-clear pulse back to the time counter once an overflow has been reported.

## Interface
- `N_BANDS`, default 4: magnitude bytes per frame; legal range 1..16.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sec` in 6: current second count, 0..59, from the time counter.
- `min` in 6: current minute count, 0..59, from the time counter.
- `ovf` in 1: sticky wrap flag from the time counter.
- `frame_valid` in 1: upstream frame offered; held until accepted.
- `frame_data` in 8*N_BANDS: band magnitudes; band k is bits [8k+7:8k].
- `frame_ready` out 1: packer can accept a frame.
- `out_data` out 8: record byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts a byte when it is high together with `out_valid`.
- `rst_ovf` out 1: one-cycle pulse that clears the time counter's `ovf`.

## Operation
- **States:** IDLE, MIN, SEC, BAND, CHK.
- **IDLE**
  - `frame_ready`=1, `out_valid`=0.
  - On `frame_valid & frame_ready`, capture in that cycle: `min`, `sec`, `ovf` into `ovf_l`, and all of `frame_data`.
  - Go to MIN.
- **MIN:** `out_data` = {2'b10, min_l}.
- **SEC:** `out_data` = {ovf_l, 1'b0, sec_l}.
- **BAND**
  - `out_data` = band[idx].
  - idx runs 0..N_BANDS-1.
  - Leave for CHK after band N_BANDS-1 is accepted.
- **CHK:** `out_data` = XOR of every preceding byte of this record. Go to IDLE when it is accepted.
- **Outputs per state:** `out_valid`=1 in MIN, SEC, BAND and CHK. `frame_ready`=0 in every state except IDLE.
- **Advancing:** state and idx advance only on `out_valid & out_ready`. With `out_ready`=0, `out_data` and `out_valid` are held stable.
- **Checksum accumulator**
  - Cleared on capture.
  - XORs in each byte as it is accepted.
  - 8-bit, so no width growth.
- **Overflow handling**
  - If captured `ovf`=1, `rst_ovf` pulses high in the cycle after capture.
  - `ovf` rising while the packer is busy is not lost: the time counter holds it sticky, and it is reported in the next record.
- **Upstream backpressure:** no frame is dropped. Upstream holds `frame_valid` while `frame_ready`=0.
- **Unused values:** `min_l`/`sec_l` values above 59 are passed through unchanged.

## Timing
- **Reset values:** state IDLE, idx 0, checksum 0x00, `out_valid` 0, `out_data` 0x00, `frame_ready` 1, `rst_ovf` 0.
- **Reset mid-record:** record abandoned; all outputs at reset values the cycle after `reset` is sampled high. No `rst_ovf` pulse follows.
- **Latency:**
  - Capture at cycle T.
  - First byte valid at T+1.
  - With `out_ready` held 1, the CHK byte is accepted at T+N_BANDS+3.
  - IDLE with `frame_ready`=1 at T+N_BANDS+4.
- **Sustained rate:** minimum record period N_BANDS+4 cycles.
- **Simultaneous events**
  - `ovf` rising in the capture cycle: the sampled value is captured.
  - `reset` together with `frame_valid`: reset wins and nothing is captured.

## Structure
- Shared package `spectro_pkg` holds:
  - the state enum
  - header sync constant 2'b10
  - record length constant N_BANDS+3
- Single module, no sub-module. The byte mux and checksum are inline.

## Test plan
- **Basic record.** Stimulus: `min`=5, `sec`=42, `ovf`=0, bands {0x11,0x22,0x33,0x44}, `out_ready`=1. Required: bytes 0x85, 0x2A, 0x11, 0x22, 0x33, 0x44, 0xEB on consecutive cycles T+1..T+7, and `rst_ovf` never high.
- **Overflow record.** Stimulus: `min`=0, `sec`=0, `ovf`=1, all bands 0x00. Required: bytes 0x80, 0x80, 0x00×4, checksum 0x00, and `rst_ovf` high exactly at T+1.
- **Downstream backpressure.** Stimulus: `out_ready`=0 for 3 cycles while SEC is presented. Required: 0x2A held stable with `out_valid`=1, no byte duplicated or skipped, record completes 3 cycles late.
- **Upstream stall.** Stimulus: second `frame_valid` asserted mid-record. Required: `frame_ready`=0 until IDLE, and the second frame is captured exactly once with its own time.
- **Reset mid-record.** Stimulus: `reset` during BAND idx 2. Required: `out_valid`=0 next cycle, next record starts fresh and its checksum is correct.
- **Back-to-back records.** Stimulus: N_BANDS=1, `frame_valid` held high. Required: record period of 5 cycles.
